seg_scan_decoder: RTL and testbench

Passive monitor that sits on the multiplexed seven-segment bus (`an`, `sev_seg`) driven by the parking-meter display path and reconstructs the four displayed BCD digits. It tracks the anode scan, samples segments once each digit is settled, decodes each pattern back to BCD, and assembles complete frames. A result is published only after consecutive identical frames, which gives board-level self-check and lets the bench compare displayed time against the internal counter.

---
 rtl/seg_scan_pkg.sv | 51 +++++
 rtl/seg_scan_decoder_seg7_to_bcd.sv | 33 +++
 rtl/seg_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan monitor.
// Holds the active-low segment codes (bit0 = a ... bit6 = g), the digit count,
// the scan FSM state type and the anode-pattern helper functions.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BCD_W      = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } scan_state_e;

    // Exactly one anode driven low.
    function automatic logic onehot_low(input logic [3:0] a);
        return ($countones(~a) == 1);
    endfunction

    // Two or more anodes driven low at once.
    function automatic logic multi_low(input logic [3:0] a);
        return ($countones(~a) > 1);
    endfunction

    // Slot number of a one-hot-low anode pattern.
    function automatic logic [1:0] slot_index(input logic [3:0] a);
        logic [1:0] idx;
        case (a)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational seven-segment (active-low) to BCD decoder.
// Ports: seg - segment pattern; bcd - decoded digit (0 for blank/invalid);
//        is_blank - all segments off; is_invalid - pattern not in the table.
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [BCD_W-1:0] bcd,
    output logic             is_blank,
    output logic             is_invalid
);

    always_comb begin
        bcd        = 4'd0;
        is_blank   = 1'b0;
        is_invalid = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive monitor of a multiplexed 4-digit seven-segment bus. Follows the
// anode scan, samples segments once each digit has settled, decodes them to
// BCD and publishes a frame after MATCH_FRAMES consecutive identical frames.
// Ports: clk, rst_n (async active-low); an[3:0] anodes (active-low, an[0] =
//        ones); sev_seg[6:0] segments (active-low); digits {th,hu,te,on};
//        digits_valid; frame_done pulse; code_err pulse; anode_err pulse;
//        blank (only when SEG_SCAN_BLANK_EN is defined).
// Build option: SEG_SCAN_BLANK_EN - accept all-off pattern as a blank digit.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MATCH_FRAMES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [SEG_W-1:0]        sev_seg,
    output logic [15:0]             digits,
    output logic                    digits_valid,
    output logic                    frame_done,
`ifdef SEG_SCAN_BLANK_EN
    output logic                    blank,
`endif
    output logic                    code_err,
    output logic                    anode_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned MCH_W = 4;

    logic [3:0]       an_s1, an_s2, an_d, an_cur;
    logic [6:0]       seg_s1, seg_s2;
    scan_state_e      state;
    logic [CNT_W-1:0] settle_cnt;
    logic [3:0]       captured;
    logic [15:0]      slot_val, prev_val;
    logic [3:0]       slot_blank, prev_blank;
    logic             prev_ok;
    logic [MCH_W-1:0] match_cnt;

    logic [3:0]       dec_bcd;
    logic             dec_blank, dec_invalid;

    seg7_to_bcd u_dec (
        .seg        (seg_s2),
        .bcd        (dec_bcd),
        .is_blank   (dec_blank),
        .is_invalid (dec_invalid)
    );

    // Frame contents as they would be after the current capture.
    logic [1:0]       cap_idx;
    logic [3:0]       cap_bit, cap_set, cap_blank;
    logic [15:0]      cap_val;
    logic             cap_bad, frame_full, frame_eq;
    logic [MCH_W-1:0] match_next;
`ifdef SEG_SCAN_BLANK_EN
    logic             all_blank, mixed_blank;
`endif

    always_comb begin
        cap_idx   = slot_index(an_cur);
        cap_bit   = 4'd1 << cap_idx;
        // A repeated slot restarts the frame with just that digit.
        cap_set   = captured[cap_idx] ? cap_bit : (captured | cap_bit);
        cap_val   = slot_val;
        cap_val[{cap_idx, 2'b00} +: 4] = dec_bcd;
        cap_blank = slot_blank;
        cap_blank[cap_idx] = dec_blank;
`ifdef SEG_SCAN_BLANK_EN
        cap_bad     = dec_invalid;
        all_blank   = (cap_blank == 4'hF);
        mixed_blank = (|cap_blank) && !all_blank;
`else
        cap_bad     = dec_invalid | dec_blank;
`endif
        frame_full = (cap_set == 4'hF);
        frame_eq   = prev_ok && (cap_val == prev_val) && (cap_blank == prev_blank);
        if (!frame_eq)
            match_next = MCH_W'(1);
        else if (match_cnt == 4'hF)
            match_next = 4'hF;
        else
            match_next = match_cnt + MCH_W'(1);
    end

    // Synchronizers, scan FSM, frame assembly and publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1        <= 4'hF;
            an_s2        <= 4'hF;
            an_d         <= 4'hF;
            an_cur       <= 4'hF;
            seg_s1       <= SEG_BLANK;
            seg_s2       <= SEG_BLANK;
            state        <= IDLE;
            settle_cnt   <= '0;
            captured     <= '0;
            slot_val     <= '0;
            slot_blank   <= '0;
            prev_val     <= '0;
            prev_blank   <= '0;
            prev_ok      <= 1'b0;
            match_cnt    <= '0;
            digits       <= '0;
            digits_valid <= 1'b0;
            frame_done   <= 1'b0;
            code_err     <= 1'b0;
            anode_err    <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
            blank        <= 1'b0;
`endif
        end else begin
            an_s1      <= an;
            an_s2      <= an_s1;
            an_d       <= an_s2;
            seg_s1     <= sev_seg;
            seg_s2     <= seg_s1;
            frame_done <= 1'b0;
            code_err   <= 1'b0;
            anode_err  <= 1'b0;

            if (multi_low(an_s2)) begin
                // Pulse once on entry into the illegal pattern; match count kept.
                if (!multi_low(an_d))
                    anode_err <= 1'b1;
                captured <= '0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (onehot_low(an_s2)) begin
                            state      <= SETTLE;
                            an_cur     <= an_s2;
                            settle_cnt <= '0;
                        end
                    end
                    SETTLE: begin
                        if (an_s2 == 4'hF) begin
                            state <= IDLE;
                        end else if (an_s2 != an_cur) begin
                            an_cur     <= an_s2;
                            settle_cnt <= '0;
                        end else if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                            state <= CAPTURE;
                        end else begin
                            settle_cnt <= settle_cnt + CNT_W'(1);
                        end
                    end
                    CAPTURE: begin
                        state <= HOLD;
                        if (cap_bad) begin
                            code_err  <= 1'b1;
                            captured  <= '0;
                            match_cnt <= '0;
                        end else if (frame_full) begin
                            captured <= '0;
`ifdef SEG_SCAN_BLANK_EN
                            if (mixed_blank) begin
                                code_err  <= 1'b1;
                                match_cnt <= '0;
                            end else
`endif
                            begin
                                prev_val   <= cap_val;
                                prev_blank <= cap_blank;
                                prev_ok    <= 1'b1;
                                if (match_next == MCH_W'(MATCH_FRAMES)) begin
                                    match_cnt    <= '0;
                                    frame_done   <= 1'b1;
                                    digits_valid <= 1'b1;
`ifdef SEG_SCAN_BLANK_EN
                                    blank <= all_blank;
                                    if (!all_blank)
                                        digits <= cap_val;
`else
                                    digits <= cap_val;
`endif
                                end else begin
                                    match_cnt <= match_next;
                                end
                            end
                        end else begin
                            captured   <= cap_set;
                            slot_val   <= cap_val;
                            slot_blank <= cap_blank;
                        end
                    end
                    HOLD: begin
                        if (an_s2 == 4'hF) begin
                            state <= IDLE;
                        end else if (an_s2 != an_cur) begin
                            state      <= SETTLE;
                            an_cur     <= an_s2;
                            settle_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed testbench for seg_scan_decoder: drives anode scans with
// hand-chosen segment patterns and checks published digits and pulses.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  sev_seg;
    logic [15:0] digits;
    logic        digits_valid;
    logic        frame_done;
    logic        code_err;
    logic        anode_err;
`ifdef SEG_SCAN_BLANK_EN
    logic        blank;
`endif

    int n_vec;
    int n_err;
    int n_done, n_code, n_anode;
    int d0, c0, a0;

    seg_scan_decoder #(.SETTLE_CYCLES(4), .MATCH_FRAMES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .an           (an),
        .sev_seg      (sev_seg),
        .digits       (digits),
        .digits_valid (digits_valid),
        .frame_done   (frame_done),
`ifdef SEG_SCAN_BLANK_EN
        .blank        (blank),
`endif
        .code_err     (code_err),
        .anode_err    (anode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (code_err)   n_code++;
        if (anode_err)  n_anode++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        d0 = n_done;
        c0 = n_code;
        a0 = n_anode;
    endtask

    task automatic show(input int idx, input logic [6:0] seg, input int dwell);
        an      = ~(4'b0001 << idx);
        sev_seg = seg;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        an      = 4'hF;
        sev_seg = 7'h7F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full scan, ones digit first.
    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        show(0, s0, 20);
        show(1, s1, 20);
        show(2, s2, 20);
        show(3, s3, 20);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        n_done = 0; n_code = 0; n_anode = 0;
        rst_n = 1'b0; an = 4'hF; sev_seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_valid",  32'(digits_valid), 32'h0);
        check("rst_done",   32'(frame_done), 32'h0);
        check("rst_code",   32'(code_err), 32'h0);
        check("rst_anode",  32'(anode_err), 32'h0);
`ifdef SEG_SCAN_BLANK_EN
        check("rst_blank",  32'(blank), 32'h0);
`endif
        rst_n = 1'b1;
        idle(5);

        // Two identical scans of 0127 publish once.
        snap();
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        check("t1_no_pub_yet", 32'(n_done - d0), 32'd0);
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        idle(5);
        check("t1_digits", 32'(digits), 32'h0127);
        check("t1_valid",  32'(digits_valid), 32'h1);
        check("t1_done",   32'(n_done - d0), 32'd1);
        check("t1_code",   32'(n_code - c0), 32'd0);

        // 0127 then 0126: no publish until 0126 repeats.
        snap();
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        scan(7'h02, 7'h24, 7'h79, 7'h40);
        check("t2_no_pub",    32'(n_done - d0), 32'd0);
        check("t2_digits_hold", 32'(digits), 32'h0127);
        scan(7'h02, 7'h24, 7'h79, 7'h40);
        check("t2_digits", 32'(digits), 32'h0126);
        check("t2_done",   32'(n_done - d0), 32'd1);

        // Bad tens pattern, then two clean 0127 frames.
        snap();
        scan(7'h02, 7'h7E, 7'h79, 7'h40);
        check("t3_code",       32'(n_code - c0), 32'd1);
        check("t3_digits_hold", 32'(digits), 32'h0126);
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        idle(5);
        check("t3_digits", 32'(digits), 32'h0127);
        check("t3_done",   32'(n_done - d0), 32'd1);

        // Two anodes low together.
        snap();
        an = 4'b1100; sev_seg = 7'h78;
        repeat (10) @(posedge clk);
        #1;
        idle(5);
        check("t4_anode",  32'(n_anode - a0), 32'd1);
        check("t4_done",   32'(n_done - d0), 32'd0);
        check("t4_code",   32'(n_code - c0), 32'd0);
        check("t4_digits", 32'(digits), 32'h0127);

        // Two all-blank frames.
        snap();
        scan(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        scan(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        idle(5);
        check("t5_digits", 32'(digits), 32'h0127);
`ifdef SEG_SCAN_BLANK_EN
        check("t5_blank", 32'(blank), 32'h1);
        check("t5_done",  32'(n_done - d0), 32'd1);
        check("t5_code",  32'(n_code - c0), 32'd0);
`else
        check("t5_done",  32'(n_done - d0), 32'd0);
        check("t5_code",  32'(n_code - c0), 32'd8);
`endif

        // Reset after two slots of a frame.
        show(0, 7'h78, 20);
        show(1, 7'h24, 20);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_digits", 32'(digits), 32'h0);
        check("t6_rst_valid",  32'(digits_valid), 32'h0);
        check("t6_rst_done",   32'(frame_done), 32'h0);
`ifdef SEG_SCAN_BLANK_EN
        check("t6_rst_blank",  32'(blank), 32'h0);
`endif
        an = 4'hF; sev_seg = 7'h7F;
        rst_n = 1'b1;
        idle(3);
        snap();
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        check("t6_one_frame", 32'(n_done - d0), 32'd0);
        check("t6_valid_lo",  32'(digits_valid), 32'h0);
        scan(7'h78, 7'h24, 7'h79, 7'h40);
        idle(5);
        check("t6_done",   32'(n_done - d0), 32'd1);
        check("t6_digits", 32'(digits), 32'h0127);
        check("t6_valid",  32'(digits_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
